// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits, odd parity, stop, ack.
// Define PS2_TX_TIMEOUT_EN to add a per-transfer watchdog of TIMEOUT_CYCLES clocks.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic       ps2ClkLow,
    output logic       ps2DataLow,
    input  logic [7:0] txData,
    input  logic       txStart,
    output logic       busy,
    output logic       done,
    output logic       txErr
);

    localparam int unsigned MAXC =
        (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] INH_DATA = CW'(INHIBIT_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_BITS,
        S_ACK,
        S_FINISH
    } state_t;

    state_t      r_state;
    logic [1:0]  r_clk_sync;
    logic [1:0]  r_dat_sync;
    logic        r_clk_prev;
    logic [9:0]  r_shift;
    logic [3:0]  r_idx;
    logic [CW-1:0] r_cnt;
    logic        r_ack;
    logic        w_fall;
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] r_wd;
`endif

    assign w_fall = r_clk_prev & ~r_clk_sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
            r_shift    <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_ack      <= 1'b0;
            ps2ClkLow  <= 1'b0;
            ps2DataLow <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            txErr      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            r_wd       <= '0;
`endif
        end else begin
            r_clk_sync <= {r_clk_sync[0], PS2Clk};
            r_dat_sync <= {r_dat_sync[0], PS2Data};
            r_clk_prev <= r_clk_sync[1];
            done       <= 1'b0;
            txErr      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (txStart) begin
                        // frame image: stop, odd parity, data (LSB sent first)
                        r_shift   <= {1'b1, ~^txData, txData};
                        r_cnt     <= '0;
                        busy      <= 1'b1;
                        ps2ClkLow <= 1'b1;
                        r_state   <= S_INHIBIT;
`ifdef PS2_TX_TIMEOUT_EN
                        r_wd      <= CW'(1);
`endif
                    end
                end
                S_INHIBIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // start bit overlaps the final inhibit cycle only
                    if (r_cnt == INH_DATA) begin
                        ps2DataLow <= 1'b1;
                    end
                    if (r_cnt == INH_LAST) begin
                        ps2ClkLow <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_fall) begin
                        ps2DataLow <= ~r_shift[0];
                        r_idx      <= 4'd1;
                        r_state    <= S_BITS;
                    end
                end
                S_BITS: begin
                    if (w_fall) begin
                        ps2DataLow <= ~r_shift[r_idx];
                        if (r_idx == 4'd9) begin
                            r_state <= S_ACK;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                S_ACK: begin
                    if (w_fall) begin
                        r_ack   <= ~r_dat_sync[1];
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    done    <= r_ack;
                    txErr   <= ~r_ack;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            if (r_state != S_IDLE && r_state != S_FINISH) begin
                if (r_wd == WD_LAST) begin
                    ps2ClkLow  <= 1'b0;
                    ps2DataLow <= 1'b0;
                    busy       <= 1'b0;
                    txErr      <= 1'b1;
                    r_state    <= S_IDLE;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, PS/2 device model and a
// per-cycle reference model of the host-side outputs.
`timescale 1ns/1ps
module tb_ps2_host_tx;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int INH = 2000;
`else
    localparam int INH = 10000;
`endif
    localparam int TMO = 5000;
    localparam int HP  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txStart = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       PS2Clk, PS2Data;
    logic       ps2ClkLow, ps2DataLow, busy, done, txErr;

    assign PS2Clk  = ~(ps2ClkLow | dev_clk_low);
    assign PS2Data = ~(ps2DataLow | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .PS2Clk(PS2Clk),
        .PS2Data(PS2Data),
        .ps2ClkLow(ps2ClkLow),
        .ps2DataLow(ps2DataLow),
        .txData(txData),
        .txStart(txStart),
        .busy(busy),
        .done(done),
        .txErr(txErr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_err   = 0;
    int dev_falls = 0;
    bit m_busy = 1'b0;
    bit m_exp_ack = 1'b1;
    int m_t = 0;
    int c11 = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    // Reference model: busy, line drive and pulses derived from the
    // protocol rules and the cycles elapsed since txStart was accepted.
    always @(negedge clk) begin
        if (done) n_done++;
        if (txErr) n_err++;
        if (!rst) begin
            check("rst_clklow", ps2ClkLow, 0);
            check("rst_datalow", ps2DataLow, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_err", txErr, 0);
            m_busy = 1'b0;
        end else begin
            if (m_busy) m_t++;
            if (!m_busy) begin
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
                check("idle_err", txErr, 0);
                check("idle_clklow", ps2ClkLow, 0);
                check("idle_datalow", ps2DataLow, 0);
            end
`ifdef PS2_TX_TIMEOUT_EN
            else if (m_t == TMO) begin
                check("wd_err", txErr, 1);
                check("wd_done", done, 0);
                check("wd_busy", busy, 0);
                check("wd_clklow", ps2ClkLow, 0);
                check("wd_datalow", ps2DataLow, 0);
                m_busy = 1'b0;
            end
`endif
            else if (dev_falls >= 11) begin
                c11++;
                check("end_clklow", ps2ClkLow, 0);
                if (!busy) begin
                    check("end_done", done, 32'(m_exp_ack));
                    check("end_err", txErr, 32'(!m_exp_ack));
                    m_busy = 1'b0;
                end else begin
                    check("early_done", done, 0);
                    check("early_err", txErr, 0);
                    if (c11 > 12) begin
                        check("end_window", busy, 0);
                        m_busy = 1'b0;
                    end
                end
            end else begin
                check("frame_busy", busy, 1);
                check("frame_done", done, 0);
                check("frame_err", txErr, 0);
                check("inhibit_clk", ps2ClkLow, 32'(m_t <= INH));
                if (m_t >= INH && dev_falls == 0)
                    check("start_bit", ps2DataLow, 1);
            end
            if (txStart && !m_busy) begin
                m_busy = 1'b1;
                m_t = 0;
                c11 = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic device(input int pulses, input bit ack, input bit inject,
                          output logic [10:0] rx);
        int w;
        rx = '0;
        w = 0;
        while (!(ps2ClkLow === 1'b0 && ps2DataLow === 1'b1) && w < INH + 50) begin
            tick(1);
            w++;
        end
        check("start_seen", 32'(w < INH + 50), 1);
        if (w < INH + 50) begin
            for (int p = 1; p <= pulses; p++) begin
                if (p == 11) begin
                    tick(3);
                    rx[10] = PS2Data;
                    if (ack) dev_data_low = 1'b1;
                    tick(HP - 3);
                end else if (inject && p == 4) begin
                    txData = 8'h00;
                    txStart = 1'b1;
                    tick(1);
                    txStart = 1'b0;
                    tick(HP - 1);
                    rx[p-1] = PS2Data;
                end else begin
                    tick(HP);
                    rx[p-1] = PS2Data;
                end
                dev_clk_low = 1'b1;
                dev_falls++;
                tick(HP);
                dev_clk_low = 1'b0;
            end
            dev_data_low = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] d, input int pulses, input bit ack,
                        input bit inject, output logic [10:0] rx,
                        output int inh_len);
        dev_falls = 0;
        m_exp_ack = ack;
        txData = d;
        txStart = 1'b1;
        tick(1);
        txStart = 1'b0;
        txData = ~d;
        inh_len = 0;
        while (ps2ClkLow === 1'b1 && inh_len < INH + 20) begin
            inh_len++;
            tick(1);
        end
        device(pulses, ack, inject, rx);
    endtask

    initial begin
        logic [10:0] rx;
        int inh, d0, e0;
        #1 rst = 1'b0;
        tick(3);
        check("reset_busy", busy, 0);
        check("reset_clklow", ps2ClkLow, 0);
        rst = 1'b1;
        tick(5);

        d0 = n_done; e0 = n_err;
        send(8'hED, 11, 1'b1, 1'b0, rx, inh);
        check("ed_frame", rx, 11'h7DA);
        tick(20);
        check("ed_done_count", n_done - d0, 1);
        check("ed_err_count", n_err - e0, 0);
        check("ed_busy_low", busy, 0);

        d0 = n_done; e0 = n_err;
        send(8'hF4, 11, 1'b1, 1'b0, rx, inh);
        check("f4_frame", rx, 11'h5E8);
        check("f4_inhibit_len", inh, INH);
        tick(20);
        check("f4_done_count", n_done - d0, 1);

        d0 = n_done; e0 = n_err;
        send(8'hFF, 11, 1'b0, 1'b0, rx, inh);
        check("ff_frame", rx, frame_of(8'hFF));
        tick(20);
        check("ff_err_count", n_err - e0, 1);
        check("ff_done_count", n_done - d0, 0);

        d0 = n_done; e0 = n_err;
        send(8'hED, 11, 1'b1, 1'b1, rx, inh);
        check("ignore_frame", rx, frame_of(8'hED));
        tick(20);
        check("ignore_done_count", n_done - d0, 1);
        check("ignore_busy_low", busy, 0);

        d0 = n_done; e0 = n_err;
        send(8'hA5, 5, 1'b1, 1'b0, rx, inh);
        tick(3);
        check("abort_pre_busy", busy, 1);
        check("abort_pre_datalow", ps2DataLow, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_clklow", ps2ClkLow, 0);
        check("abort_datalow", ps2DataLow, 0);
        check("abort_busy", busy, 0);
        tick(3);
        rst = 1'b1;
        tick(20);
        check("abort_done_count", n_done - d0, 0);
        check("abort_err_count", n_err - e0, 0);

`ifdef PS2_TX_TIMEOUT_EN
        d0 = n_done; e0 = n_err;
        send(8'h12, 0, 1'b1, 1'b0, rx, inh);
        tick(TMO - INH + 20);
        check("wd_err_count", n_err - e0, 1);
        check("wd_done_count", n_done - d0, 0);
        check("wd_busy_low", busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000, the number of clk cycles PS2Clk is held low before the start bit (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, the watchdog limit per transfer in clk cycles (20 ms).
REQ-003 SHALL have port clk, input, 1 bit: system clock, single clock domain.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port PS2Clk, input, 1 bit: PS/2 clock line as sensed at the pin.
REQ-006 SHALL have port PS2Data, input, 1 bit: PS/2 data line as sensed at the pin.
REQ-007 SHALL have port ps2ClkLow, output, 1 bit: 1 means drive PS2Clk low, 0 means release it.
REQ-008 SHALL have port ps2DataLow, output, 1 bit: 1 means drive PS2Data low, 0 means release it.
REQ-009 SHALL have port txData, input, 8 bits: command byte to send to the keyboard.
REQ-010 SHALL have port txStart, input, 1 bit: one-cycle request to send; accepted only when busy=0.
REQ-011 SHALL have port busy, output, 1 bit: high from txStart acceptance until done or error.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when the device acknowledged.
REQ-013 SHALL have port txErr, output, 1 bit: one-cycle pulse when ack is missing or the watchdog expires.

Function
REQ-014 SHALL pass PS2Clk and PS2Data through 2-flop synchronizers; a falling edge is sync=0 with the previous sync=1.
REQ-015 SHALL have the states IDLE, INHIBIT, START, BITS, ACK, FINISH.
REQ-016 IDLE: on txStart=1, SHALL latch txData, compute odd parity (parity bit = ~^txData), assert busy on the next cycle, and go to INHIBIT.
REQ-017 INHIBIT: SHALL hold ps2ClkLow=1 for exactly INHIBIT_CYCLES cycles, then assert ps2DataLow=1 (start bit) and go to START.
REQ-018 START: SHALL release ps2ClkLow one cycle after ps2DataLow asserts, keep ps2DataLow=1, and wait for the first PS2Clk falling edge.
REQ-019 BITS: on each PS2Clk falling edge, SHALL present the next frame bit: data bits 0..7 LSB first, then parity, then stop; ps2DataLow = ~bit.
REQ-020 The stop bit SHALL be sent as a released line (ps2DataLow=0); the 4-bit bit counter SHALL not wrap within a frame.
REQ-021 ACK: after the stop-bit edge, SHALL sample synced PS2Data on the next PS2Clk falling edge: 0 means ack and go to FINISH with done, 1 means go to FINISH with txErr.
REQ-022 FINISH: SHALL pulse done or txErr for exactly one cycle, clear busy in the same cycle, and return to IDLE.
REQ-023 SHALL ignore txStart while busy=1, with no queueing.
REQ-024 SHALL never assert ps2ClkLow outside INHIBIT, and never assert ps2ClkLow and ps2DataLow together except on the transition cycle of REQ-017.
REQ-025 SHALL keep the latched byte stable for the whole frame even if txData changes.

Reset
REQ-026 While rst=0, SHALL immediately force: state IDLE, ps2ClkLow=0, ps2DataLow=0, busy=0, done=0, txErr=0, counters 0, synchronizers 1.
REQ-027 Reset asserted mid-frame SHALL release both lines at once; no done or txErr pulse is produced for the aborted frame.

Configuration
REQ-028 With macro PS2_TX_TIMEOUT_EN defined, a counter SHALL run from leaving IDLE; reaching TIMEOUT_CYCLES in any state except IDLE or FINISH SHALL release both lines, pulse txErr, and return to IDLE.
REQ-029 Without PS2_TX_TIMEOUT_EN, no watchdog logic SHALL exist and the block SHALL wait indefinitely for device clocks.

Verification
REQ-030 txData=0xED, device model clocks and acks: frame start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1 -> done pulses once, busy drops.
REQ-031 txData=0xF4: parity bit 0 -> done; PS2Clk held low for exactly 10000 cycles before the start bit.
REQ-032 txData=0xFF, device leaves PS2Data high on the ack clock -> txErr pulses once, done stays 0.
REQ-033 Second txStart=1 with txData=0x00 issued mid-frame of 0xED -> ignored; the frame still carries 0xED.
REQ-034 rst=0 after 4 data bits -> ps2ClkLow=0 and ps2DataLow=0 the same cycle, busy=0, and no pulses.
REQ-035 With PS2_TX_TIMEOUT_EN defined and TIMEOUT_CYCLES=5000, the device never clocks -> txErr at cycle 5000 and lines released.
